// File: rtl/adt7420_reader.sv
// ADT7420 poller: periodic I2C read of the 16-bit temperature register.
// Every bit is split into four quarter-ticks. Only open-drain enables are driven.
module adt7420_reader #(
  parameter int unsigned CLK_HZ     = 200000000,
  parameter int unsigned I2C_HZ     = 100000,
  parameter logic [6:0]  DEV_ADDR   = 7'h48,
  parameter int unsigned POLL_TICKS = 25000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_in,
  output logic [7:0]  temp,
  output logic [15:0] raw,
  output logic        valid,
  output logic        ack_err,
  output logic        busy
);
  localparam int unsigned QDIV = CLK_HZ / (4 * I2C_HZ);
  localparam int unsigned DW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int unsigned PW   = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;

  typedef enum logic [2:0] {
    S_WAIT, S_START, S_WBYTE, S_WACK, S_RSTART, S_RBYTE, S_MACK, S_STOP
  } state_t;

  state_t        state_q;
  logic [DW-1:0] div_q, div_d;
  logic          tick;
  logic [PW-1:0] poll_q;
  logic [1:0]    q_q;
  logic [2:0]    bit_q;
  logic [2:0]    idx_q;
  logic [7:0]    tx_q, rx_q, msb_q;
  logic          nack_q;
  logic [1:0]    sync_q;
  logic          sda_s;
  logic          scl_oe_q, sda_oe_q, valid_q, ack_err_q, busy_q;
  logic [7:0]    temp_q;
  logic [15:0]   raw_q;

  always_comb begin
    tick  = (div_q == DW'(QDIV - 1));
    div_d = tick ? '0 : div_q + DW'(1);
  end

  assign sda_s   = sync_q[1];
  assign scl_oe  = scl_oe_q;
  assign sda_oe  = sda_oe_q;
  assign temp    = temp_q;
  assign raw     = raw_q;
  assign valid   = valid_q;
  assign ack_err = ack_err_q;
  assign busy    = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_WAIT;
      div_q     <= '0;
      poll_q    <= '0;
      q_q       <= '0;
      bit_q     <= '0;
      idx_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      msb_q     <= '0;
      nack_q    <= 1'b0;
      sync_q    <= '1;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
      valid_q   <= 1'b0;
      ack_err_q <= 1'b0;
      busy_q    <= 1'b0;
      temp_q    <= '0;
      raw_q     <= '0;
    end else begin
      div_q   <= div_d;
      sync_q  <= {sync_q[0], sda_in};
      valid_q <= 1'b0;
      if (tick) begin
        q_q <= q_q + 2'd1;
        unique case (state_q)
          S_WAIT: begin
            q_q      <= '0;
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b0;
            if (poll_q == PW'(POLL_TICKS - 1)) begin
              poll_q  <= '0;
              state_q <= S_START;
              busy_q  <= 1'b1;
              idx_q   <= 3'd0;
              nack_q  <= 1'b0;
            end else begin
              poll_q <= poll_q + PW'(1);
            end
          end
          // START and repeated START share timing: SDA falls at q2 with SCL high.
          S_START, S_RSTART: begin
            case (q_q)
              2'd0: sda_oe_q <= 1'b0;
              2'd1: scl_oe_q <= 1'b0;
              2'd2: sda_oe_q <= 1'b1;
              default: begin
                scl_oe_q <= 1'b1;
                bit_q    <= '0;
                tx_q     <= {DEV_ADDR, (state_q == S_RSTART)};
                state_q  <= S_WBYTE;
              end
            endcase
          end
          S_WBYTE: begin
            case (q_q)
              2'd0: begin scl_oe_q <= 1'b1; sda_oe_q <= ~tx_q[7]; end
              2'd1: scl_oe_q <= 1'b0;
              2'd2: ;
              default: begin
                scl_oe_q <= 1'b1;
                tx_q     <= {tx_q[6:0], 1'b0};
                bit_q    <= bit_q + 3'd1;
                if (bit_q == 3'd7) state_q <= S_WACK;
              end
            endcase
          end
          S_WACK: begin
            case (q_q)
              2'd0: begin scl_oe_q <= 1'b1; sda_oe_q <= 1'b0; end
              2'd1: scl_oe_q <= 1'b0;
              2'd2: if (sda_s) begin nack_q <= 1'b1; ack_err_q <= 1'b1; end
              default: begin
                scl_oe_q <= 1'b1;
                bit_q    <= '0;
                if (nack_q) begin
                  state_q <= S_STOP;
                end else if (idx_q == 3'd0) begin
                  idx_q   <= 3'd1;
                  tx_q    <= 8'h00;
                  state_q <= S_WBYTE;
                end else if (idx_q == 3'd1) begin
                  idx_q   <= 3'd2;
                  state_q <= S_RSTART;
                end else begin
                  idx_q   <= 3'd3;
                  state_q <= S_RBYTE;
                end
              end
            endcase
          end
          S_RBYTE: begin
            case (q_q)
              2'd0: begin scl_oe_q <= 1'b1; sda_oe_q <= 1'b0; end
              2'd1: scl_oe_q <= 1'b0;
              2'd2: rx_q <= {rx_q[6:0], sda_s};
              default: begin
                scl_oe_q <= 1'b1;
                bit_q    <= bit_q + 3'd1;
                if (bit_q == 3'd7) state_q <= S_MACK;
              end
            endcase
          end
          S_MACK: begin
            case (q_q)
              2'd0: begin scl_oe_q <= 1'b1; sda_oe_q <= (idx_q == 3'd3); end
              2'd1: scl_oe_q <= 1'b0;
              2'd2: ;
              default: begin
                scl_oe_q <= 1'b1;
                bit_q    <= '0;
                if (idx_q == 3'd3) begin
                  msb_q   <= rx_q;
                  idx_q   <= 3'd4;
                  state_q <= S_RBYTE;
                end else begin
                  state_q <= S_STOP;
                end
              end
            endcase
          end
          S_STOP: begin
            case (q_q)
              2'd0: begin scl_oe_q <= 1'b1; sda_oe_q <= 1'b1; end
              2'd1: scl_oe_q <= 1'b0;
              2'd2: sda_oe_q <= 1'b0;
              default: begin
                state_q <= S_WAIT;
                busy_q  <= 1'b0;
                if (!nack_q) begin
                  raw_q     <= {msb_q, rx_q};
                  temp_q    <= {msb_q[6:0], rx_q[7]};
                  valid_q   <= 1'b1;
                  ack_err_q <= 1'b0;
                end
              end
            endcase
          end
          default: state_q <= S_WAIT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_adt7420_reader.sv
// Bench for adt7420_reader: behavioural I2C slave and bus monitor, plus a
// vector table of transactions checked against a byte-level reference model.
module tb_adt7420_reader;
  localparam int unsigned CLK_HZ    = 2000;
  localparam int unsigned I2C_HZ    = 100;
  localparam int unsigned POLL      = 20;
  localparam int          QDIV      = CLK_HZ / (4 * I2C_HZ);
  localparam int          TXN_TICKS = 4 + 3 * (8 + 1) * 4 + 4 + 2 * (8 + 1) * 4 + 4;
  localparam int          EV_ACK    = 1000;
  localparam int          EV_START  = 2000;
  localparam int          EV_STOP   = 3000;
  localparam int          NV        = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic scl_oe, sda_oe;
  logic [7:0] temp;
  logic [15:0] raw;
  logic valid, ack_err, busy;
  logic slave_pull = 1'b0;
  logic scl_w, sda_w;

  assign scl_w = ~scl_oe;
  assign sda_w = ~(sda_oe | slave_pull);

  always #5 clk = ~clk;

  adt7420_reader #(
    .CLK_HZ(CLK_HZ),
    .I2C_HZ(I2C_HZ),
    .DEV_ADDR(7'h48),
    .POLL_TICKS(POLL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .scl_oe(scl_oe),
    .sda_oe(sda_oe),
    .sda_in(sda_w),
    .temp(temp),
    .raw(raw),
    .valid(valid),
    .ack_err(ack_err),
    .busy(busy)
  );

  // Slave / bus monitor.
  logic [7:0] sl_msb = 8'h00, sl_lsb = 8'h00;
  logic sl_nack = 1'b0;
  logic scl_p = 1'b1, sda_p = 1'b1;
  bit active = 0, addr_ph = 0, slave_tx = 0;
  int bitn = 0, tx_cnt = 0;
  logic [7:0] rx = 8'h00, txsh = 8'h00;
  logic ackbit = 1'b1;
  int mon[$];

  always @(scl_w or sda_w or rst_n) begin
    if (rst_n !== 1'b1) begin
      active = 0;
      slave_pull = 1'b0;
    end else if (scl_w === 1'b1 && scl_p === 1'b1 && sda_p === 1'b1 && sda_w === 1'b0) begin
      mon.push_back(EV_START);
      active = 1; addr_ph = 1; slave_tx = 0; bitn = 0; tx_cnt = 0;
    end else if (scl_w === 1'b1 && scl_p === 1'b1 && sda_p === 1'b0 && sda_w === 1'b1) begin
      if (active) mon.push_back(EV_STOP);
      active = 0; slave_pull = 1'b0;
    end else if (scl_p === 1'b0 && scl_w === 1'b1 && active) begin
      if (bitn < 8) rx = {rx[6:0], sda_w}; else ackbit = sda_w;
      bitn++;
    end else if (scl_p === 1'b1 && scl_w === 1'b0 && active) begin
      if (bitn == 8) begin
        mon.push_back(int'(rx));
        if (slave_tx) slave_pull = 1'b0;
        else if (addr_ph) begin
          slave_pull = (rx[7:1] == 7'h48) && !sl_nack;
          slave_tx = slave_pull && rx[0];
          addr_ph = 0;
        end else slave_pull = 1'b1;
      end else if (bitn == 9) begin
        mon.push_back(EV_ACK + int'(ackbit));
        bitn = 0;
        if (slave_tx && tx_cnt < 2 && (tx_cnt == 0 || ackbit == 1'b0)) begin
          txsh = (tx_cnt == 0) ? sl_msb : sl_lsb;
          tx_cnt++;
          slave_pull = ~txsh[7];
          txsh = {txsh[6:0], 1'b0};
        end else slave_pull = 1'b0;
      end else if (bitn >= 1 && slave_tx && tx_cnt > 0) begin
        slave_pull = ~txsh[7];
        txsh = {txsh[6:0], 1'b0};
      end
    end
    scl_p = scl_w;
    sda_p = sda_w;
  end

  // Cycle counter, valid-pulse log and SCL period statistics.
  int cyc = 0, valid_cnt = 0, last_valid_cyc = 0;
  int scl_last = 0, hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0;
  logic scl_lv = 1'b1, busy_p = 1'b0;
  bit scl_have = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    int d;
    if (busy === 1'b1 && busy_p !== 1'b1) begin
      scl_have = 0; hi_min = 1 << 30; hi_max = 0; lo_min = 1 << 30; lo_max = 0;
    end
    busy_p = busy;
    if (valid === 1'b1) begin valid_cnt++; last_valid_cyc = cyc; end
    if (scl_w !== scl_lv) begin
      if (scl_have) begin
        d = cyc - scl_last;
        if (scl_lv === 1'b1) begin
          if (d < hi_min) hi_min = d;
          if (d > hi_max) hi_max = d;
        end else begin
          if (d < lo_min) lo_min = d;
          if (d > lo_max) lo_max = d;
        end
      end
      scl_have = (busy === 1'b1);
      scl_last = cyc;
      scl_lv = scl_w;
    end
  end

  typedef struct {
    logic [7:0]  msb;
    logic [7:0]  lsb;
    bit          nack;
    logic [7:0]  exp_temp;
    logic [15:0] exp_raw;
    int          exp_valid;
    bit          exp_err;
  } vec_t;

  vec_t vecs[NV];
  int n_pass = 0, n_chk = 0;
  bit prev_ok = 0;
  int prev_cyc = 0;
  logic [7:0] mdl_temp = 8'h00;
  logic [15:0] mdl_raw = 16'h0000;

  function automatic vec_t mk(input logic [7:0] m, input logic [7:0] l, input bit nk,
                              input logic [7:0] et, input logic [15:0] er, input int ev, input bit ee);
    vec_t v;
    v.msb = m; v.lsb = l; v.nack = nk;
    v.exp_temp = et; v.exp_raw = er; v.exp_valid = ev; v.exp_err = ee;
    return v;
  endfunction

  // Reference: integer degrees are the 9-bit value msb*2 + lsb bit 7, wrapped to 8 bits.
  function automatic vec_t model(input logic [7:0] m, input logic [7:0] l, input bit nk);
    int t9;
    if (!nk) begin
      t9 = int'(m) * 2 + int'(l) / 128;
      mdl_temp = 8'(t9 % 256);
      mdl_raw = 16'(int'(m) * 256 + int'(l));
    end
    return mk(m, l, nk, mdl_temp, mdl_raw, nk ? 0 : 1, nk);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic wait_busy(input logic lvl, input int maxc, output bit ok);
    ok = 0;
    for (int k = 0; k < maxc; k++) begin
      @(posedge clk); #1;
      if (busy === lvl) begin ok = 1; break; end
    end
  endtask

  task automatic release_and_time(input string name);
    int edges;
    bit seen;
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0; seen = 0;
    for (int k = 0; k < 4 * int'(POLL) * QDIV; k++) begin
      @(posedge clk); edges++; #1;
      if (busy === 1'b1) begin seen = 1; break; end
    end
    chk({name, "_seen"}, seen, 1);
    chk(name, edges, int'(POLL) * QDIV);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " scl_oe"}, scl_oe, 0);
    chk({tag, " sda_oe"}, sda_oe, 0);
    chk({tag, " temp"}, temp, 0);
    chk({tag, " raw"}, raw, 0);
    chk({tag, " valid"}, valid, 0);
    chk({tag, " ack_err"}, ack_err, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    bit ok;
    int mb, vb, nbad;
    int e[$];
    sl_msb = v.msb; sl_lsb = v.lsb; sl_nack = v.nack;
    wait_busy(1'b1, 4 * int'(POLL) * QDIV, ok);
    chk({tag, " start"}, ok, 1);
    mb = mon.size(); vb = valid_cnt;
    wait_busy(1'b0, 2 * TXN_TICKS * QDIV, ok);
    chk({tag, " done"}, ok, 1);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " valid_pulses"}, valid_cnt - vb, v.exp_valid);
    chk({tag, " temp"}, temp, v.exp_temp);
    chk({tag, " raw"}, raw, v.exp_raw);
    chk({tag, " ack_err"}, ack_err, v.exp_err);
    e = '{EV_START, 8'h90};
    if (v.nack) e.push_back(EV_ACK + 1);
    else e = {e, EV_ACK, 8'h00, EV_ACK, EV_START, 8'h91, EV_ACK,
              int'(v.msb), EV_ACK, int'(v.lsb), EV_ACK + 1};
    e.push_back(EV_STOP);
    chk({tag, " bus_len"}, mon.size() - mb, e.size());
    nbad = 0;
    for (int k = 0; k < e.size() && mb + k < mon.size(); k++)
      if (mon[mb + k] != e[k]) nbad++;
    chk({tag, " bus_seq_errs"}, nbad, 0);
    chk_rng({tag, " scl_hi_min"}, hi_min, 2 * QDIV - 1, 2 * QDIV + 1);
    chk_rng({tag, " scl_hi_max"}, hi_max, 2 * QDIV - 1, 2 * QDIV + 1);
    chk_rng({tag, " scl_lo_min"}, lo_min, 2 * QDIV - 1, 2 * QDIV + 1);
    chk_rng({tag, " scl_lo_max"}, lo_max, 2 * QDIV - 1, 2 * QDIV + 1);
    if (v.exp_valid == 1 && prev_ok)
      chk({tag, " valid_spacing"}, last_valid_cyc - prev_cyc, (int'(POLL) + TXN_TICKS) * QDIV);
    prev_ok = (v.exp_valid == 1);
    prev_cyc = last_valid_cyc;
  endtask

  initial begin
    bit ok;
    rst_n = 1'b1;
    vecs[0] = mk(8'h0C, 8'h80, 0, 8'h19, 16'h0C80, 1, 0);
    vecs[1] = mk(8'h1A, 8'h00, 0, 8'h34, 16'h1A00, 1, 0);
    vecs[2] = mk(8'h00, 8'h00, 1, 8'h34, 16'h1A00, 0, 1);
    vecs[3] = mk(8'hFF, 8'h00, 0, 8'hFE, 16'hFF00, 1, 0);
    vecs[4] = mk(8'h12, 8'h34, 1, 8'hFE, 16'hFF00, 0, 1);
    mdl_temp = 8'hFE; mdl_raw = 16'hFF00;
    for (int i = 5; i < NV; i++)
      vecs[i] = model(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
    sl_msb = vecs[0].msb; sl_lsb = vecs[0].lsb; sl_nack = vecs[0].nack;

    #2 rst_n = 1'b0;
    #1 check_reset_values("reset");
    repeat (3) @(posedge clk);
    release_and_time("first_start_delay");

    for (int i = 0; i < NV; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted while the msb is being read.
    sl_msb = 8'h55; sl_lsb = 8'h80; sl_nack = 1'b0;
    wait_busy(1'b1, 4 * int'(POLL) * QDIV, ok);
    chk("midrst start", ok, 1);
    begin
      int mb;
      mb = mon.size(); ok = 0;
      for (int k = 0; k < TXN_TICKS * QDIV; k++) begin
        @(posedge clk); #1;
        if (mon.size() - mb >= 8) begin ok = 1; break; end
      end
    end
    chk("midrst reached_rbyte", ok, 1);
    repeat (8 * QDIV + 1) @(posedge clk);
    chk("midrst scl_low_before", scl_oe, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    repeat (3) @(posedge clk);
    release_and_time("midrst_start_delay");
    prev_ok = 0;
    mdl_temp = 8'h00; mdl_raw = 16'h0000;
    run_txn(model(8'h55, 8'h80, 0), "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
